i2c_init_sequencer: RTL and testbench

Sequences the board's power-up register programming (ADV7511 HDMI transmitter, MAX9850 headphone DAC) through the byte-level I2C write engine. Walks a synchronous ROM table of {device, register, value} entries, issues one write transaction per entry, and retries on NACK. Sits between the table ROM and the I2C engine in the 28 MHz domain, replacing fixed power-on sequencing. It also provides restart on request or, optionally, on HDMI hot-plug.

---
 rtl/i2c_init_sequencer.sv | 278 +++++++++++++++++++++++++++
 tb/tb_i2c_init_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : i2c_init_sequencer
// Description : Walks a {dev, reg, val} ROM table at power-up and issues one
//               I2C write per entry through the byte-level engine, retrying
//               on NACK. Define I2C_SEQ_HPD_REINIT_EN to also restart the
//               table on a debounced HDMI hot-plug rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_init_sequencer #(
    parameter int TABLE_LEN      = 64,
    parameter int MAX_RETRY      = 3,
    parameter int POWERUP_CYCLES = 5600000,
    parameter int GAP_CYCLES     = 2800,
    parameter int HPD_DEBOUNCE   = 280000,
    localparam int IDX_W         = (TABLE_LEN > 1) ? $clog2(TABLE_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             resend,
    input  logic             hpd,
    output logic [IDX_W-1:0] tbl_index,
    input  logic [23:0]      tbl_entry,
    output logic             wr_req,
    input  logic             wr_ready,
    output logic [7:0]       wr_dev,
    output logic [7:0]       wr_reg,
    output logic [7:0]       wr_val,
    input  logic             wr_done,
    input  logic             wr_nack,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] err_index
);

    localparam int c_CNT_W   = 23;
    localparam int c_CMP_W   = c_CNT_W + 1;
    localparam int c_RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [c_CNT_W-1:0]   c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]   c_FETCH_LAST = c_CNT_W'(2);
    localparam logic [c_CMP_W-1:0]   c_CMP_ONE    = c_CMP_W'(1);
    localparam logic [c_CMP_W-1:0]   c_PWR_LEN    = c_CMP_W'(POWERUP_CYCLES);
    localparam logic [c_CMP_W-1:0]   c_GAP_LEN    = c_CMP_W'(GAP_CYCLES);
    localparam logic [c_RETRY_W-1:0] c_MAX_RETRY  = c_RETRY_W'(MAX_RETRY);
    localparam logic [c_RETRY_W-1:0] c_RETRY_ONE  = c_RETRY_W'(1);
    localparam logic [IDX_W:0]       c_IDX_ONE    = (IDX_W + 1)'(1);
    localparam logic [IDX_W:0]       c_TABLE_END  = (IDX_W + 1)'(TABLE_LEN);
    localparam logic [7:0]           c_DEV_END    = 8'hFF;

    typedef enum logic [2:0] {
        S_POWERUP = 3'd0,
        S_FETCH   = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_GAP     = 3'd4,
        S_DONE    = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_next;
    logic [IDX_W-1:0]       r_index;
    logic [IDX_W-1:0]       w_index_next;
    logic [c_RETRY_W-1:0]   r_retry;
    logic [c_RETRY_W-1:0]   w_retry_next;
    logic                   r_pending;
    logic                   w_pending_next;
    logic                   r_nack;
    logic                   w_nack_next;
    logic [IDX_W-1:0]       r_err_index;
    logic [IDX_W-1:0]       w_err_index_next;
    logic [7:0]             r_dev, r_reg, r_val;
    logic [7:0]             w_dev_next, w_reg_next, w_val_next;
    logic                   r_wr_req, r_busy, r_done, r_error;

    logic                   w_restart;
    logic                   w_go_fetch;
    logic                   w_pwr_end;
    logic                   w_gap_end;
    logic [IDX_W:0]         w_index_inc;

    // ------------------------------------------------------------------------
    // Restart source: resend pulse, optionally OR'ed with debounced hot-plug
    // ------------------------------------------------------------------------
`ifdef I2C_SEQ_HPD_REINIT_EN
    localparam logic [c_CMP_W-1:0] c_HPD_LEN = c_CMP_W'(HPD_DEBOUNCE);

    logic [1:0]         r_hpd_sync;
    logic               r_hpd_level;
    logic               r_hpd_rise;
    logic [c_CNT_W-1:0] r_hpd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hpd_sync  <= 2'b00;
            r_hpd_level <= 1'b0;
            r_hpd_rise  <= 1'b0;
            r_hpd_cnt   <= '0;
        end else begin
            r_hpd_sync <= {r_hpd_sync[0], hpd};
            r_hpd_rise <= 1'b0;
            // Count consecutive cycles the synchronized level differs from the accepted one
            if (r_hpd_sync[1] == r_hpd_level) begin
                r_hpd_cnt <= '0;
            end else if (({1'b0, r_hpd_cnt} + c_CMP_ONE) >= c_HPD_LEN) begin
                r_hpd_level <= r_hpd_sync[1];
                r_hpd_rise  <= r_hpd_sync[1];
                r_hpd_cnt   <= '0;
            end else if (!(&r_hpd_cnt)) begin
                r_hpd_cnt <= r_hpd_cnt + c_CNT_ONE;
            end
        end
    end

    assign w_restart = resend | r_hpd_rise;
`else
    logic [1:0] w_unused_hpd;
    assign w_unused_hpd = {hpd, (HPD_DEBOUNCE > 0)};
    assign w_restart    = resend;
`endif

    assign w_pwr_end   = ({1'b0, r_cnt} + c_CMP_ONE) >= c_PWR_LEN;
    assign w_gap_end   = ({1'b0, r_cnt} + c_CMP_ONE) >= c_GAP_LEN;
    assign w_index_inc = {1'b0, r_index} + c_IDX_ONE;

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = (&r_cnt) ? r_cnt : r_cnt + c_CNT_ONE;
        w_index_next     = r_index;
        w_retry_next     = r_retry;
        w_pending_next   = r_pending;
        w_nack_next      = r_nack;
        w_err_index_next = r_err_index;
        w_dev_next       = r_dev;
        w_reg_next       = r_reg;
        w_val_next       = r_val;
        w_go_fetch       = 1'b0;

        case (r_state)
            S_POWERUP: begin
                if (w_restart || w_pwr_end) begin
                    w_go_fetch = 1'b1;
                end
            end
            S_FETCH: begin
                if (w_restart) begin
                    w_go_fetch = 1'b1;
                end else if (r_cnt == c_FETCH_LAST) begin
                    if (tbl_entry[23:16] == c_DEV_END) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_dev_next   = tbl_entry[23:16];
                        w_reg_next   = tbl_entry[15:8];
                        w_val_next   = tbl_entry[7:0];
                        w_state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // A restart coinciding with the handshake is deferred: the engine owns the transfer
                if (wr_ready) begin
                    w_state_next   = S_WAIT;
                    w_pending_next = w_restart;
                end else if (w_restart) begin
                    w_go_fetch = 1'b1;
                end
            end
            S_WAIT: begin
                if (wr_done) begin
                    if (r_pending || w_restart) begin
                        w_go_fetch = 1'b1;
                    end else begin
                        w_nack_next  = wr_nack;
                        w_cnt_next   = '0;
                        w_state_next = S_GAP;
                    end
                end else if (w_restart) begin
                    w_pending_next = 1'b1;
                end
            end
            S_GAP: begin
                if (w_restart) begin
                    w_go_fetch = 1'b1;
                end else if (w_gap_end) begin
                    if (!r_nack) begin
                        w_retry_next = '0;
                        if (w_index_inc == c_TABLE_END) begin
                            w_state_next = S_DONE;
                        end else begin
                            w_index_next = w_index_inc[IDX_W-1:0];
                            w_cnt_next   = '0;
                            w_state_next = S_FETCH;
                        end
                    end else if (r_retry < c_MAX_RETRY) begin
                        w_retry_next = r_retry + c_RETRY_ONE;
                        w_state_next = S_ISSUE;
                    end else begin
                        w_err_index_next = r_index;
                        w_state_next     = S_ERROR;
                    end
                end
            end
            S_DONE, S_ERROR: begin
                if (w_restart) begin
                    w_go_fetch = 1'b1;
                end
            end
            default: begin
                w_state_next = S_POWERUP;
            end
        endcase

        if (w_go_fetch) begin
            w_state_next   = S_FETCH;
            w_cnt_next     = '0;
            w_index_next   = '0;
            w_retry_next   = '0;
            w_pending_next = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State and output registers; outputs decode the next state so they stay
    // aligned with the state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_POWERUP;
            r_cnt       <= '0;
            r_index     <= '0;
            r_retry     <= '0;
            r_pending   <= 1'b0;
            r_nack      <= 1'b0;
            r_err_index <= '0;
            r_dev       <= 8'h00;
            r_reg       <= 8'h00;
            r_val       <= 8'h00;
            r_wr_req    <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_index     <= w_index_next;
            r_retry     <= w_retry_next;
            r_pending   <= w_pending_next;
            r_nack      <= w_nack_next;
            r_err_index <= w_err_index_next;
            r_dev       <= w_dev_next;
            r_reg       <= w_reg_next;
            r_val       <= w_val_next;
            r_wr_req    <= (w_state_next == S_ISSUE);
            r_busy      <= !((w_state_next == S_DONE) || (w_state_next == S_ERROR));
            r_done      <= (w_state_next == S_DONE);
            r_error     <= (w_state_next == S_ERROR);
        end
    end

    assign tbl_index = r_index;
    assign wr_req    = r_wr_req;
    assign wr_dev    = r_dev;
    assign wr_reg    = r_reg;
    assign wr_val    = r_val;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign err_index = r_err_index;

endmodule
`default_nettype wire

// File: tb/tb_i2c_init_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_i2c_init_sequencer
// Description : Directed self-checking bench: ROM table model plus a simple
//               I2C engine responder with configurable NACKs and latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_init_sequencer;

    localparam int c_TABLE_LEN = 8;
    localparam int c_MAX_RETRY = 3;
    localparam int c_PWR       = 10;
    localparam int c_GAP       = 4;
    localparam int c_HPD_DB    = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        resend = 1'b0;
    logic        hpd = 1'b0;
    logic [2:0]  tbl_index;
    logic [23:0] tbl_entry = 24'h0;
    logic        wr_req;
    logic        wr_ready = 1'b1;
    logic [7:0]  wr_dev, wr_reg, wr_val;
    logic        wr_done = 1'b0;
    logic        wr_nack = 1'b0;
    logic        busy, done, error;
    logic [2:0]  err_index;

    i2c_init_sequencer #(
        .TABLE_LEN      (c_TABLE_LEN),
        .MAX_RETRY      (c_MAX_RETRY),
        .POWERUP_CYCLES (c_PWR),
        .GAP_CYCLES     (c_GAP),
        .HPD_DEBOUNCE   (c_HPD_DB)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .resend    (resend),
        .hpd       (hpd),
        .tbl_index (tbl_index),
        .tbl_entry (tbl_entry),
        .wr_req    (wr_req),
        .wr_ready  (wr_ready),
        .wr_dev    (wr_dev),
        .wr_reg    (wr_reg),
        .wr_val    (wr_val),
        .wr_done   (wr_done),
        .wr_nack   (wr_nack),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_index (err_index)
    );

    always #5 clk = ~clk;

    logic [23:0] rom [0:7];
    int          cyc = 0;

    always @(posedge clk) tbl_entry <= rom[tbl_index];
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Engine responder: logs each handshake, answers after done_lat cycles
    logic [23:0] xfer_q[$];
    int          xfer_cyc[$];
    int          done_lat  = 2;
    logic [7:0]  nack_reg  = 8'h00;
    int          nack_left = 0;

    initial begin : engine
        logic nk;
        forever begin
            @(negedge clk);
            if (!rst && wr_req && wr_ready) begin
                xfer_q.push_back({wr_dev, wr_reg, wr_val});
                xfer_cyc.push_back(cyc);
                nk = (wr_reg == nack_reg) && (nack_left != 0);
                if (nk && nack_left > 0) nack_left--;
                repeat (done_lat) @(negedge clk);
                wr_done = 1'b1;
                wr_nack = nk;
                @(negedge clk);
                wr_done = 1'b0;
                wr_nack = 1'b0;
            end
        end
    end

    task automatic pulse_resend();
        @(negedge clk);
        resend = 1'b1;
        @(negedge clk);
        resend = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int max_cyc);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done || error) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_xfers(input string tag, input int n, input int max_cyc);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (xfer_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic measure_first_req(input string tag);
        int first;
        first = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (wr_req) begin
                first = i;
                break;
            end
        end
        check_eq(tag, first, 13);
    endtask

    function automatic int count_entry(input logic [23:0] e);
        int n;
        n = 0;
        foreach (xfer_q[i]) if (xfer_q[i] == e) n++;
        return n;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin : main
        int bad;
        rom[0] = 24'h724110;
        rom[1] = 24'h729803;
        rom[2] = 24'h20000F;
        for (int i = 3; i < 8; i++) rom[i] = 24'hFFFFFF;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_wr_req", wr_req, 0);
        check_eq("rst_busy", busy, 1);
        check_eq("rst_done", done, 0);
        check_eq("rst_error", error, 0);
        check_eq("rst_index", tbl_index, 0);
        check_eq("rst_fields", {wr_dev, wr_reg, wr_val}, 0);
        check_eq("rst_err_index", err_index, 0);

        // Clean run: three writes in order
        rst = 1'b0;
        measure_first_req("first_req_cycle");
        wait_end("run1_end", 400);
        check_eq("run1_done", done, 1);
        check_eq("run1_error", error, 0);
        check_eq("run1_busy", busy, 0);
        check_eq("run1_count", xfer_q.size(), 3);
        check_eq("run1_x0", xfer_q[0], 24'h724110);
        check_eq("run1_x1", xfer_q[1], 24'h729803);
        check_eq("run1_x2", xfer_q[2], 24'h20000F);

        // Entry 1 NACKs twice then acks
        xfer_q.delete(); xfer_cyc.delete();
        nack_reg = 8'h98; nack_left = 2;
        pulse_resend();
        wait_end("run2_end", 400);
        check_eq("run2_done", done, 1);
        check_eq("run2_error", error, 0);
        check_eq("run2_count", xfer_q.size(), 5);
        check_eq("run2_x0", xfer_q[0], 24'h724110);
        check_eq("run2_e1_tries", count_entry(24'h729803), 3);
        check_eq("run2_x4", xfer_q[4], 24'h20000F);
        check_eq("run2_ack_spacing", xfer_cyc[1] - xfer_cyc[0], 10);
        check_eq("run2_retry_spacing", xfer_cyc[2] - xfer_cyc[1], 7);

        // Entry 2 always NACKs: four attempts then error
        xfer_q.delete(); xfer_cyc.delete();
        nack_reg = 8'h00; nack_left = -1;
        pulse_resend();
        wait_end("run3_end", 400);
        check_eq("run3_error", error, 1);
        check_eq("run3_done", done, 0);
        check_eq("run3_busy", busy, 0);
        check_eq("run3_err_index", err_index, 2);
        check_eq("run3_e2_tries", count_entry(24'h20000F), 4);
        repeat (40) @(negedge clk);
        check_eq("run3_quiet_count", xfer_q.size(), 6);
        check_eq("run3_quiet_req", wr_req, 0);
        nack_left = 0;
        xfer_q.delete(); xfer_cyc.delete();
        pulse_resend();
        wait_end("run3b_end", 400);
        check_eq("run3b_done", done, 1);
        check_eq("run3b_error", error, 0);
        check_eq("run3b_x0", xfer_q[0], 24'h724110);
        check_eq("run3b_count", xfer_q.size(), 3);

        // Engine stalls wr_ready for 50 cycles
        xfer_q.delete(); xfer_cyc.delete();
        wr_ready = 1'b0;
        pulse_resend();
        bad = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_req) begin
                bad = 0;
                break;
            end
        end
        check_eq("stall_req_seen", bad, 0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!wr_req || ({wr_dev, wr_reg, wr_val} != 24'h724110)) bad++;
        end
        check_eq("stall_hold_errors", bad, 0);
        @(posedge clk);
        #2 wr_ready = 1'b1;
        wait_end("stall_end", 400);
        check_eq("stall_e0_count", count_entry(24'h724110), 1);
        check_eq("stall_count", xfer_q.size(), 3);

        // resend while the engine is busy with entry 0
        xfer_q.delete(); xfer_cyc.delete();
        done_lat = 10;
        pulse_resend();
        wait_xfers("wait_first_xfer", 1, 50);
        @(negedge clk);
        resend = 1'b1;
        @(negedge clk);
        resend = 1'b0;
        wait_end("wait_rs_end", 400);
        check_eq("wait_rs_done", done, 1);
        check_eq("wait_rs_count", xfer_q.size(), 4);
        check_eq("wait_rs_e0_count", count_entry(24'h724110), 2);
        check_eq("wait_rs_x1", xfer_q[1], 24'h724110);
        check_eq("wait_rs_x3", xfer_q[3], 24'h20000F);
        check_eq("wait_rs_spacing", xfer_cyc[1] - xfer_cyc[0], 14);
        done_lat = 2;

        // Hot-plug behaviour
        xfer_q.delete(); xfer_cyc.delete();
`ifdef I2C_SEQ_HPD_REINIT_EN
        hpd = 1'b1;
        repeat (10) @(negedge clk);
        hpd = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("hpd_glitch_done", done, 1);
        check_eq("hpd_glitch_count", xfer_q.size(), 0);
        hpd = 1'b1;
        repeat (c_HPD_DB + 5) @(negedge clk);
        wait_end("hpd_end", 400);
        check_eq("hpd_restart_count", xfer_q.size(), 3);
        check_eq("hpd_restart_x0", xfer_q[0], 24'h724110);
        check_eq("hpd_restart_done", done, 1);
`else
        hpd = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("hpd_ignored_done", done, 1);
        check_eq("hpd_ignored_busy", busy, 0);
        check_eq("hpd_ignored_count", xfer_q.size(), 0);
`endif
        hpd = 1'b0;
        repeat (5) @(negedge clk);

        // Reset in the middle of a transaction
        xfer_q.delete(); xfer_cyc.delete();
        pulse_resend();
        wait_xfers("mid_rst_xfer", 1, 50);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("mid_rst_wr_req", wr_req, 0);
        check_eq("mid_rst_busy", busy, 1);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_index", tbl_index, 0);
        check_eq("mid_rst_fields", {wr_dev, wr_reg, wr_val}, 0);
        @(negedge clk);
        rst = 1'b0;
        measure_first_req("mid_rst_first_req");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
